// File: rtl/lane_rx_sequencer_pkg.sv
// Shared types and constants for the lane receive sequencer.
package lane_rx_sequencer_pkg;
  localparam int CONN_ID_WIDTH = 3;
  localparam logic [CONN_ID_WIDTH-1:0] CONN_NONE = '1;

  typedef enum logic {IDLE, SERVE} seq_state_t;
endpackage

// File: rtl/lane_rx_sequencer_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr+1, wrapping.
module lane_rx_sequencer_rr_pick #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    int           j;
    logic [IW-1:0] jj;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int i = N; i >= 1; i--) begin
      j  = (int'(ptr) + i) % N;
      jj = IW'(j);
      if (req[jj]) begin
        idx   = W'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lane_rx_sequencer.sv
// Drives the shared conn/lane selector bus: serves each connection's lanes in
// order, one lane per consumed last beat, round-robin between messages.
module lane_rx_sequencer
  import lane_rx_sequencer_pkg::*;
#(
  parameter int NUM_CONNS = 4,
  parameter int NUM_LANES = 4,
  parameter int LW        = $clog2(NUM_LANES) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_programmed,
  input  logic                     cfg_valid,
  input  logic [CONN_ID_WIDTH-1:0] cfg_conn,
  input  logic [LW-1:0]            cfg_num_lanes,
  input  logic [NUM_CONNS-1:0]     conn_pending,
  input  logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     out_last,
  output logic [CONN_ID_WIDTH-1:0] curr_conn_id,
  output logic [CONN_ID_WIDTH-1:0] curr_lane_id,
  output logic                     seq_busy,
  output logic [31:0]              msg_count,
  output logic                     cfg_err
);
  localparam int CW = CONN_ID_WIDTH;

  seq_state_t                   state_q, state_d;
  logic [NUM_CONNS-1:0][LW-1:0] num_lanes_q, num_lanes_d;
  logic [CW-1:0]                conn_q, conn_d;
  logic [CW-1:0]                lane_q, lane_d;
  logic [LW-1:0]                active_q, active_d;
  logic [CW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [31:0]                  msg_count_q, msg_count_d;
  logic                         cfg_err_q, cfg_err_d;

  logic [NUM_CONNS-1:0] elig;
  logic [CW-1:0]        pick_idx;
  logic                 pick_found;
  logic [LW-1:0]        pick_lanes;
  logic                 cfg_ok;
  logic                 lane_done;
  logic                 last_lane;

  for (genvar c = 0; c < NUM_CONNS; c++) begin : g_elig
    assign elig[c] = conn_pending[c] & (|num_lanes_q[c]);
  end

  lane_rx_sequencer_rr_pick #(.N(NUM_CONNS), .W(CW)) u_rr_pick (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    pick_lanes = '0;
    for (int c = 0; c < NUM_CONNS; c++)
      if (pick_idx == CW'(c)) pick_lanes = num_lanes_q[c];
  end

  assign cfg_ok    = (cfg_conn < CW'(NUM_CONNS)) && (cfg_num_lanes <= LW'(NUM_LANES));
  assign lane_done = out_valid & out_ready & out_last;
  assign last_lane = (LW'(lane_q) + LW'(1)) == active_q;

  always_comb begin
    state_d     = state_q;
    num_lanes_d = num_lanes_q;
    conn_d      = conn_q;
    lane_d      = lane_q;
    active_d    = active_q;
    rr_ptr_d    = rr_ptr_q;
    msg_count_d = msg_count_q;
    cfg_err_d   = cfg_err_q | (cfg_valid & ~cfg_ok);

    // Table writes never touch active_q, so an in-flight message keeps its length.
    for (int c = 0; c < NUM_CONNS; c++)
      if (cfg_valid && cfg_ok && cfg_conn == CW'(c)) num_lanes_d[c] = cfg_num_lanes;

    case (state_q)
      IDLE: begin
        if (rx_programmed && pick_found) begin
          conn_d   = pick_idx;
          lane_d   = '0;
          active_d = pick_lanes;
          rr_ptr_d = pick_idx;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (lane_done) begin
          if (last_lane) begin
            msg_count_d = msg_count_q + 32'd1;
            conn_d      = CONN_NONE;
            lane_d      = '0;
            state_d     = IDLE;
          end else begin
            lane_d = lane_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_lanes_q <= '0;
      conn_q      <= CONN_NONE;
      lane_q      <= '0;
      active_q    <= '0;
      rr_ptr_q    <= CW'(NUM_CONNS - 1);
      msg_count_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_lanes_q <= num_lanes_d;
      conn_q      <= conn_d;
      lane_q      <= lane_d;
      active_q    <= active_d;
      rr_ptr_q    <= rr_ptr_d;
      msg_count_q <= msg_count_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign curr_conn_id = conn_q;
  assign curr_lane_id = lane_q;
  assign seq_busy     = (state_q == SERVE);
  assign msg_count    = msg_count_q;
  assign cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_lane_rx_sequencer.sv
// Bench for lane_rx_sequencer: vector table, directed corner sequences, and
// randomized traffic against a message-level reference model.
module tb_lane_rx_sequencer;
  import lane_rx_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_programmed = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_conn = '0;
  logic [2:0]  cfg_num_lanes = '0;
  logic [3:0]  conn_pending = '0;
  logic        out_valid = 1'b0, out_ready = 1'b0, out_last = 1'b0;
  logic [2:0]  curr_conn_id, curr_lane_id;
  logic        seq_busy, cfg_err;
  logic [31:0] msg_count;

  lane_rx_sequencer dut (
    .clk(clk), .rst_n(rst_n), .rx_programmed(rx_programmed),
    .cfg_valid(cfg_valid), .cfg_conn(cfg_conn), .cfg_num_lanes(cfg_num_lanes),
    .conn_pending(conn_pending), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .curr_conn_id(curr_conn_id), .curr_lane_id(curr_lane_id),
    .seq_busy(seq_busy), .msg_count(msg_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table of lengths, one in-flight message, rotating pointer.
  int          m_tbl[4];
  bit          m_busy;
  int          m_conn, m_lane, m_len, m_rr;
  logic [31:0] m_msgs;
  bit          m_err;

  task automatic m_reset();
    foreach (m_tbl[i]) m_tbl[i] = 0;
    m_busy = 0; m_conn = 7; m_lane = 0; m_len = 0; m_rr = 3; m_msgs = 0; m_err = 0;
  endtask

  task automatic m_step();
    int old[4];
    int c;
    if (!rst_n) begin
      m_reset();
      return;
    end
    old = m_tbl;
    if (cfg_valid) begin
      if (cfg_conn < 4 && cfg_num_lanes <= 4) m_tbl[cfg_conn] = int'(cfg_num_lanes);
      else m_err = 1;
    end
    if (!m_busy) begin
      if (rx_programmed) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_rr + k) % 4;
          if (!m_busy && conn_pending[c] && old[c] != 0) begin
            m_busy = 1; m_conn = c; m_lane = 0; m_len = old[c]; m_rr = c;
          end
        end
      end
    end else if (out_valid && out_ready && out_last) begin
      if (m_lane == m_len - 1) begin
        m_msgs = m_msgs + 1; m_busy = 0; m_conn = 7; m_lane = 0;
      end else begin
        m_lane = m_lane + 1;
      end
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    chk("mdl_conn", 32'(curr_conn_id), 32'(m_conn));
    chk("mdl_lane", 32'(curr_lane_id), 32'(m_lane));
    chk("mdl_busy", 32'(seq_busy), 32'(m_busy));
    chk("mdl_msgs", msg_count, m_msgs);
    chk("mdl_err",  32'(cfg_err), 32'(m_err));
  endtask

  task automatic idle_in();
    cfg_valid = 0; cfg_conn = 0; cfg_num_lanes = 0; conn_pending = 0;
    out_valid = 0; out_ready = 0; out_last = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic cfg_write(input int c, input int n);
    cfg_valid = 1; cfg_conn = 3'(c); cfg_num_lanes = 3'(n);
    tick();
    cfg_valid = 0;
  endtask

  task automatic beat(input bit last);
    out_valid = 1; out_ready = 1; out_last = last;
    tick();
    out_valid = 0; out_ready = 0; out_last = 0;
  endtask

  typedef struct {
    bit prog, cv;
    logic [2:0] cc, cn;
    logic [3:0] pend;
    bit v, r, l;
    logic [2:0] e_conn, e_lane;
    bit e_busy;
    int e_msgs;
    bit e_err;
  } vec_t;

  vec_t vt[12];
  int   got[4];
  int   e2[4];
  int   ng;
  bit   prev_busy;

  initial begin
    vt[0]  = '{1, 1, 3'd1, 3'd3, 4'b0000, 0, 0, 0, 3'd7, 3'd0, 0, 0, 0};
    vt[1]  = '{1, 0, 3'd0, 3'd0, 4'b0010, 0, 0, 0, 3'd1, 3'd0, 1, 0, 0};
    vt[2]  = '{1, 0, 3'd0, 3'd0, 4'b0000, 1, 1, 1, 3'd1, 3'd1, 1, 0, 0};
    vt[3]  = '{1, 0, 3'd0, 3'd0, 4'b0000, 1, 0, 1, 3'd1, 3'd1, 1, 0, 0};
    vt[4]  = '{1, 0, 3'd0, 3'd0, 4'b0000, 0, 1, 1, 3'd1, 3'd1, 1, 0, 0};
    vt[5]  = '{1, 0, 3'd0, 3'd0, 4'b0000, 1, 1, 1, 3'd1, 3'd2, 1, 0, 0};
    vt[6]  = '{1, 0, 3'd0, 3'd0, 4'b0000, 1, 1, 0, 3'd1, 3'd2, 1, 0, 0};
    vt[7]  = '{1, 0, 3'd0, 3'd0, 4'b0000, 1, 1, 1, 3'd7, 3'd0, 0, 1, 0};
    vt[8]  = '{1, 0, 3'd0, 3'd0, 4'b0000, 1, 1, 1, 3'd7, 3'd0, 0, 1, 0};
    vt[9]  = '{1, 1, 3'd7, 3'd2, 4'b0000, 0, 0, 0, 3'd7, 3'd0, 0, 1, 1};
    vt[10] = '{1, 0, 3'd0, 3'd0, 4'b0010, 0, 0, 0, 3'd1, 3'd0, 1, 1, 1};
    vt[11] = '{1, 0, 3'd0, 3'd0, 4'b0000, 1, 1, 1, 3'd1, 3'd1, 1, 1, 1};
    e2 = '{0, 2, 0, 2};

    m_reset();
    do_reset();
    chk("rst_conn", 32'(curr_conn_id), 32'd7);
    chk("rst_lane", 32'(curr_lane_id), 32'd0);
    chk("rst_busy", 32'(seq_busy), 32'd0);
    chk("rst_msgs", msg_count, 32'd0);
    chk("rst_err",  32'(cfg_err), 32'd0);

    // Vector table: single conn, 3 lanes, non-consumed beats, illegal conn write.
    for (int i = 0; i < 12; i++) begin
      rx_programmed = vt[i].prog; cfg_valid = vt[i].cv; cfg_conn = vt[i].cc;
      cfg_num_lanes = vt[i].cn; conn_pending = vt[i].pend;
      out_valid = vt[i].v; out_ready = vt[i].r; out_last = vt[i].l;
      tick();
      chk($sformatf("vec%0d_conn", i), 32'(curr_conn_id), 32'(vt[i].e_conn));
      chk($sformatf("vec%0d_lane", i), 32'(curr_lane_id), 32'(vt[i].e_lane));
      chk($sformatf("vec%0d_busy", i), 32'(seq_busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d_msgs", i), msg_count, 32'(vt[i].e_msgs));
      chk($sformatf("vec%0d_err", i),  32'(cfg_err), 32'(vt[i].e_err));
    end

    // Round-robin between two always-pending connections.
    do_reset();
    rx_programmed = 1;
    cfg_write(0, 2);
    cfg_write(2, 2);
    conn_pending = 4'b0101; out_valid = 1; out_ready = 1; out_last = 1;
    ng = 0; prev_busy = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 11) conn_pending = 4'b0000;
      tick();
      if (seq_busy && !prev_busy && ng < 4) begin got[ng] = int'(curr_conn_id); ng++; end
      prev_busy = seq_busy;
    end
    idle_in();
    chk("rr_grants", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(got[i]), 32'(e2[i]));
    chk("rr_msgs", msg_count, 32'd4);

    // Multi-beat lanes: lane advances only on the last beat.
    do_reset();
    rx_programmed = 1;
    cfg_write(0, 2);
    conn_pending = 4'b0001;
    tick();
    conn_pending = 4'b0000;
    for (int b = 1; b <= 8; b++) begin
      beat(b % 4 == 0);
      if (b < 4)       chk($sformatf("mb_lane_b%0d", b), 32'(curr_lane_id), 32'd0);
      else if (b < 8)  chk($sformatf("mb_lane_b%0d", b), 32'(curr_lane_id), 32'd1);
      else             chk("mb_done_conn", 32'(curr_conn_id), 32'd7);
    end

    // Length rewrite mid-message keeps the latched length.
    do_reset();
    rx_programmed = 1;
    cfg_write(0, 3);
    conn_pending = 4'b0001;
    tick();
    conn_pending = 4'b0000;
    beat(1);
    cfg_write(0, 1);
    chk("rw_lane1", 32'(curr_lane_id), 32'd1);
    beat(1);
    chk("rw_lane2", 32'(curr_lane_id), 32'd2);
    beat(1);
    chk("rw_done", 32'(seq_busy), 32'd0);
    conn_pending = 4'b0001;
    tick();
    conn_pending = 4'b0000;
    beat(1);
    chk("rw_short_done", 32'(seq_busy), 32'd0);
    chk("rw_msgs", msg_count, 32'd2);

    // Oversized lane count is rejected; table keeps length 1.
    cfg_write(0, 5);
    chk("ovf_err", 32'(cfg_err), 32'd1);
    conn_pending = 4'b0001;
    tick();
    conn_pending = 4'b0000;
    beat(1);
    chk("ovf_len_kept", 32'(seq_busy), 32'd0);
    chk("ovf_err_sticky", 32'(cfg_err), 32'd1);

    // rx_programmed drop mid-message, then reset mid-message.
    cfg_write(1, 2);
    conn_pending = 4'b0010;
    tick();
    chk("prog_grant", 32'(curr_conn_id), 32'd1);
    rx_programmed = 0;
    beat(1);
    beat(1);
    chk("prog_finish", 32'(curr_conn_id), 32'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("prog_hold", 32'(curr_conn_id), 32'd7);
    end
    rx_programmed = 1;
    tick();
    chk("prog_regrant", 32'(curr_conn_id), 32'd1);
    beat(1);
    rst_n = 0;
    tick();
    chk("mrst_conn", 32'(curr_conn_id), 32'd7);
    chk("mrst_lane", 32'(curr_lane_id), 32'd0);
    chk("mrst_busy", 32'(seq_busy), 32'd0);
    chk("mrst_msgs", msg_count, 32'd0);
    chk("mrst_err",  32'(cfg_err), 32'd0);
    rst_n = 1;
    tick();
    chk("mrst_table_clear", 32'(curr_conn_id), 32'd7);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst_n         = ($urandom_range(0, 399) != 0);
      rx_programmed = ($urandom_range(0, 15) != 0);
      cfg_valid     = ($urandom_range(0, 5) == 0);
      cfg_conn      = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      cfg_num_lanes = 3'($urandom_range(0, 5));
      conn_pending  = 4'($urandom_range(0, 15));
      out_valid     = 1'($urandom_range(0, 1));
      out_ready     = ($urandom_range(0, 3) != 0);
      out_last      = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lane_rx_sequencer.md
Name: lane_rx_sequencer

Overview:
- Scheduler that drives the shared curr_conn_id / curr_lane_id selector bus read by every per-lane receive unit.
- Reassembles multi-lane messages in lane order: lane 0 of a connection, then lane 1, and so on up to lane N-1.
- Advances one lane per consumed last beat; moves to the next pending connection, round-robin, only at message boundaries.
- Sits between the lane receive units and the downstream merged-stream consumer.

Parameters:
NUM_CONNS, 4, number of connection table entries; must be ≤ 2^CONN_ID_WIDTH − 1.
NUM_LANES, 4, maximum lanes per connection; must be ≤ 2^CONN_ID_WIDTH.
LW, $clog2(NUM_LANES)+1, width of a lane-count field.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
rx_programmed  in  1  global lane-table-programmed flag; low holds the sequencer idle
cfg_valid  in  1  connection table write strobe
cfg_conn  in  CONN_ID_WIDTH  connection index to write
cfg_num_lanes  in  LW  lanes per message for that connection; 0 = disabled
conn_pending  in  NUM_CONNS  bit c = lane 0 of connection c holds data
out_valid  in  1  merged stream valid, observed only
out_ready  in  1  merged stream ready, observed only
out_last  in  1  merged stream last, observed only
curr_conn_id  out  CONN_ID_WIDTH  connection currently granted
curr_lane_id  out  CONN_ID_WIDTH  lane order index currently granted
seq_busy  out  1  high while in SERVE
msg_count  out  32  completed messages, wraps
cfg_err  out  1  sticky; set by an illegal cfg write

Behaviour:
- Reset values:
  - curr_conn_id = CONN_NONE (all ones), curr_lane_id = 0.
  - seq_busy = 0, msg_count = 0, cfg_err = 0.
  - All table entries = 0 (disabled); rr_ptr = NUM_CONNS−1.
- Connection table:
  - cfg_valid writes num_lanes[cfg_conn] on the next edge.
  - A write is illegal if cfg_conn ≥ NUM_CONNS or cfg_num_lanes > NUM_LANES. An illegal write is ignored and sets cfg_err.
- Beat consumed = out_valid & out_ready. lane_done = beat consumed & out_last.
- FSM states: IDLE, SERVE.
- IDLE:
  - Outputs curr_conn_id = CONN_NONE, so no lane matches and none is granted.
  - Eligible connection c = conn_pending[c] & num_lanes[c] ≠ 0.
  - When rx_programmed=1 and any connection is eligible, pick the first eligible at or after rr_ptr+1, with wrap-around.
  - On pick, next edge: curr_conn_id = c, curr_lane_id = 0, active_lanes latched from num_lanes[c], rr_ptr = c, go to SERVE.
  - Select latency: exactly 1 cycle from eligible to ids valid.
- SERVE, on lane_done:
  - If curr_lane_id = active_lanes−1: msg_count+1, curr_conn_id = CONN_NONE, go to IDLE.
  - Otherwise: curr_lane_id+1.
  - Beats without last change nothing.
- Grant gap: at least one IDLE cycle between messages. Back-to-back throughput is therefore N+1 cycles per N one-beat lanes.
- Table writes during SERVE:
  - They update the table but not active_lanes; the current message completes with its latched length.
  - A connection disabled mid-message still completes that message.
- rx_programmed falling:
  - In SERVE: finish the current message, then hold in IDLE.
  - In IDLE: no new selection.
- out_last with out_valid=0, or while in IDLE, is ignored.
- conn_pending is sampled only in IDLE; deasserting it during SERVE has no effect.
- Reset mid-message: immediate return to reset values. The table is cleared and must be reprogrammed.
- Fairness: a connection is not re-picked while another eligible connection waits.

Decomposition:
- Add to NetTypes: CONN_NONE constant and the seq_state_t enum {IDLE, SERVE}.
- Natural sub-module: rr_pick. Combinational round-robin first-one-from-pointer over NUM_CONNS bits, outputs index and found.
- The table, FSM and counters stay in lane_rx_sequencer.

Test Plan:
1. Reset, then program conn1 = 3 lanes and assert conn_pending[1] → after 1 cycle curr=(1,0). Three out_last beats step lane 0→1→2 → then CONN_NONE, msg_count=1.
2. conn0 = 2, conn2 = 2, both always pending, rr_ptr starts at 3 → service order 0, 2, 0, 2. msg_count=4 after 8 lane_done beats.
3. Multi-beat lanes: 4 beats per lane with last only on the 4th, conn0 = 2 → curr_lane_id changes only after beats 4 and 8.
4. While serving conn0 at lane 1 of 3, write conn0 num_lanes=1 → lane 2 is still served. The next message of conn0 uses 1 lane.
5. Write cfg_conn=7 (NUM_CONNS=4), and separately cfg_num_lanes=5 → table unchanged, cfg_err=1 and stays 1.
6. Drop rx_programmed mid-message → current message completes, then curr_conn_id = CONN_NONE despite pending data. Assert rst_n=0 mid-message → all outputs return to reset values on the next edge.
